// File: rtl/pll_pkg.sv
// Shared types for the PLL lock monitor: state encoding
// and the popcount width helper.
package pll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } pll_state_e;

  function automatic int pop_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int TRIM_W_DEF = 26;
  localparam int POP_W_DEF  = pop_w(TRIM_W_DEF);

endpackage

// File: rtl/pll_popcount.sv
// Combinational population count of a W-bit word.
// Result is wide enough to hold W itself.
module pll_popcount
  import pll_pkg::*;
#(
  parameter int W  = 26,
  parameter int CW = pop_w(W)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);

  // sum of set bits; synthesis folds the chain into an adder tree
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/pll_lock_monitor.sv
// PLL lock/acquisition monitor on the osc clock.
// Optional lock-loss interrupt: define PLL_LOCKLOSS_IRQ_EN.
module pll_lock_monitor
  import pll_pkg::*;
#(
  parameter int TRIM_W         = 26,
  parameter int DIV_W          = 5,
  parameter int STABLE_CYCLES  = 5,
  parameter int TIMEOUT_CYCLES = 50,
  parameter int TOL            = 0,
  parameter int LT_W           = 16
) (
  input  logic              osc,
  input  logic              resetb,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div,
  input  logic [TRIM_W-1:0] trim,
`ifdef PLL_LOCKLOSS_IRQ_EN
  input  logic              irq_clr,
  output logic              irq,
`endif
  output logic              locked,
  output logic              timeout,
  output logic [LT_W-1:0]   lock_time,
  output logic [1:0]        state
);

  localparam int PW   = pop_w(TRIM_W);
  localparam int DW   = PW + 1;
  localparam int SC_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [LT_W-1:0] LT_ONE  = LT_W'(1);
  localparam logic [LT_W-1:0] TO_LAST = LT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STABLE_CYCLES);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STABLE_CYCLES - 1);

  pll_state_e        state_q;
  logic [TRIM_W-1:0] trim_q;
  logic [DIV_W-1:0]  div_q;
  logic [LT_W-1:0]   wait_cnt;
  logic [SC_W-1:0]   stable_cnt;

  logic [PW-1:0] pop_now;
  logic [PW-1:0] pop_prev;
  logic [DW-1:0] pa;
  logic [DW-1:0] pb;
  logic [DW-1:0] diff;
  logic          stable;
  logic          div_chg;
  logic [LT_W-1:0] wait_nx;
  logic [SC_W-1:0] sc_nx;

  pll_popcount #(.W(TRIM_W), .CW(PW)) u_pop_now (
    .bits  (trim),
    .count (pop_now)
  );

  pll_popcount #(.W(TRIM_W), .CW(PW)) u_pop_prev (
    .bits  (trim_q),
    .count (pop_prev)
  );

  assign pa   = {1'b0, pop_now};
  assign pb   = {1'b0, pop_prev};
  assign diff = (pa >= pb) ? pa - pb : pb - pa;

  assign stable = (TOL == 0) ? (trim == trim_q)
                             : (diff <= DW'(TOL));

  assign div_chg = (div != div_q);
  assign wait_nx = (wait_cnt == '1) ? wait_cnt
                                    : wait_cnt + LT_ONE;
  assign sc_nx   = (stable_cnt == SC_MAX) ? stable_cnt
                                          : stable_cnt + SC_ONE;
  assign state   = state_q;

  // acquisition FSM with its counters and status flags
  always_ff @(posedge osc) begin
    if (!resetb) begin
      state_q    <= ST_IDLE;
      locked     <= 1'b0;
      timeout    <= 1'b0;
      lock_time  <= '0;
      trim_q     <= '0;
      div_q      <= '0;
      wait_cnt   <= '0;
      stable_cnt <= '0;
    end else begin
      trim_q <= trim;
      div_q  <= div;
      if (!enable) begin
        state_q    <= ST_IDLE;
        locked     <= 1'b0;
        timeout    <= 1'b0;
        wait_cnt   <= '0;
        stable_cnt <= '0;
      end else if (div_chg && state_q != ST_IDLE) begin
        state_q    <= ST_ACQUIRE;
        locked     <= 1'b0;
        timeout    <= 1'b0;
        wait_cnt   <= '0;
        stable_cnt <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            state_q    <= ST_ACQUIRE;
            wait_cnt   <= '0;
            stable_cnt <= '0;
          end
          ST_ACQUIRE: begin
            wait_cnt   <= wait_nx;
            stable_cnt <= stable ? sc_nx : '0;
            if (stable && stable_cnt == SC_LAST) begin
              state_q   <= ST_LOCKED;
              locked    <= 1'b1;
              lock_time <= wait_cnt + LT_ONE;
            end else if (wait_cnt == TO_LAST) begin
              state_q <= ST_TIMEOUT;
              timeout <= 1'b1;
            end
          end
          ST_LOCKED: begin
            if (!stable) begin
              state_q    <= ST_ACQUIRE;
              locked     <= 1'b0;
              wait_cnt   <= '0;
              stable_cnt <= '0;
            end
          end
          ST_TIMEOUT: begin
          end
        endcase
      end
    end
  end

`ifdef PLL_LOCKLOSS_IRQ_EN
  logic lock_lost;
  logic loss_evt;

  assign loss_evt = enable && !div_chg
                 && state_q == ST_LOCKED && !stable;
  assign irq = lock_lost;

  // sticky lock-loss flag; a new loss beats a same-cycle clear
  always_ff @(posedge osc) begin
    if (!resetb) begin
      lock_lost <= 1'b0;
    end else if (loss_evt) begin
      lock_lost <= 1'b1;
    end else if (irq_clr) begin
      lock_lost <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Scoreboard bench for pll_lock_monitor: dut0 exact compare,
// dut1 built with TOL=1. Honours PLL_LOCKLOSS_IRQ_EN.
module tb_pll_lock_monitor;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACQ  = 2'd1;
  localparam logic [1:0] LCK  = 2'd2;
  localparam logic [1:0] TMO  = 2'd3;

  localparam logic [25:0] P13 = 26'h0001FFF;
  localparam logic [25:0] P14 = 26'h0003FFF;
  localparam logic [25:0] P15 = 26'h0007FFF;
  localparam logic [25:0] TGL = 26'h2AAAAAA;

  typedef struct {
    int         cyc;
    bit         which;
    logic [1:0] st;
    logic       lk;
    logic       to;
    logic [15:0] lt;
    logic       iq;
  } exp_t;

  logic        osc;
  logic        resetb;
  logic        enable, en1;
  logic [4:0]  div, div1;
  logic [25:0] trim, trim1;
  logic        locked0, timeout0, locked1, timeout1;
  logic [15:0] lt0, lt1;
  logic [1:0]  st0, st1;
`ifdef PLL_LOCKLOSS_IRQ_EN
  logic        irq_clr;
  logic        irq0, irq1;
`endif

  exp_t sb[$];
  exp_t e;
  int   edges  = 0;
  int   n_run  = 0;
  int   n_fail = 0;

  pll_lock_monitor dut0 (
    .osc       (osc),
    .resetb    (resetb),
    .enable    (enable),
    .div       (div),
    .trim      (trim),
`ifdef PLL_LOCKLOSS_IRQ_EN
    .irq_clr   (irq_clr),
    .irq       (irq0),
`endif
    .locked    (locked0),
    .timeout   (timeout0),
    .lock_time (lt0),
    .state     (st0)
  );

  pll_lock_monitor #(.TOL(1)) dut1 (
    .osc       (osc),
    .resetb    (resetb),
    .enable    (en1),
    .div       (div1),
    .trim      (trim1),
`ifdef PLL_LOCKLOSS_IRQ_EN
    .irq_clr   (1'b0),
    .irq       (irq1),
`endif
    .locked    (locked1),
    .timeout   (timeout1),
    .lock_time (lt1),
    .state     (st1)
  );

  initial osc = 1'b0;
  always #5 osc = ~osc;

  always @(posedge osc) edges <= edges + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge osc);
    #1;
  endtask

  task automatic push(input int k, input bit w,
                      input logic [1:0] st, input logic lk,
                      input logic to, input logic [15:0] lt,
                      input logic iq);
    exp_t x;
    x.cyc = edges + k;
    x.which = w;
    x.st = st;
    x.lk = lk;
    x.to = to;
    x.lt = lt;
    x.iq = iq;
    sb.push_back(x);
  endtask

  // monitor: pop every expectation due at this edge count
  always @(negedge osc) begin
    while (sb.size() > 0 && sb[0].cyc <= edges) begin
      logic [1:0]  g_st;
      logic        g_lk, g_to, g_iq, bad;
      logic [15:0] g_lt;
      e = sb.pop_front();
      g_st = e.which ? st1 : st0;
      g_lk = e.which ? locked1 : locked0;
      g_to = e.which ? timeout1 : timeout0;
      g_lt = e.which ? lt1 : lt0;
      bad = (g_st !== e.st) || (g_lk !== e.lk) ||
            (g_to !== e.to) || (g_lt !== e.lt) ||
            (e.cyc != edges);
`ifdef PLL_LOCKLOSS_IRQ_EN
      g_iq = e.which ? irq1 : irq0;
      bad = bad || (g_iq !== e.iq);
`else
      g_iq = e.iq;
`endif
      n_run++;
      if (bad) begin
        n_fail++;
        $display("FAIL chk dut%0d edge %0d: got st=%0d lk=%0d to=%0d lt=%0d irq=%0d, want st=%0d lk=%0d to=%0d lt=%0d irq=%0d (due %0d)",
                 e.which, edges, g_st, g_lk, g_to, g_lt, g_iq,
                 e.st, e.lk, e.to, e.lt, e.iq, e.cyc);
      end
    end
  end

  initial begin
    resetb = 1'b0;
    enable = 1'b0; en1 = 1'b0;
    div = '0; div1 = '0;
    trim = '0; trim1 = '0;
`ifdef PLL_LOCKLOSS_IRQ_EN
    irq_clr = 1'b0;
`endif
    tick(2);
    push(0, 0, IDLE, 0, 0, 0, 0);
    push(0, 1, IDLE, 0, 0, 0, 0);
    tick(1);

    // 1: constant trim locks after 5 ACQUIRE cycles
    resetb = 1'b1;
    enable = 1'b1; div = 5'd17; trim = P13;
    push(1, 0, ACQ, 0, 0, 0, 0);
    push(5, 0, ACQ, 0, 0, 0, 0);
    push(6, 0, LCK, 1, 0, 5, 0);
    tick(7);

    // 3: bit 13 flip drops lock, then relock
    trim = P13 ^ 26'h0002000;
    push(1, 0, ACQ, 0, 0, 5, 1);
    push(5, 0, ACQ, 0, 0, 5, 1);
    push(6, 0, LCK, 1, 0, 5, 1);
    tick(7);

`ifdef PLL_LOCKLOSS_IRQ_EN
    irq_clr = 1'b1;
    push(1, 0, LCK, 1, 0, 5, 0);
    tick(1);
    irq_clr = 1'b0;
    tick(1);
`endif

    // 4: div change from LOCKED re-acquires
    div = 5'd18;
    push(1, 0, ACQ, 0, 0, 5, 0);
    push(5, 0, ACQ, 0, 0, 5, 0);
    push(6, 0, LCK, 1, 0, 5, 0);
    tick(7);

    // 2: toggling trim times out 50 cycles after entry
    div = 5'd19;
    push(1, 0, ACQ, 0, 0, 5, 0);
    push(30, 0, ACQ, 0, 0, 5, 0);
    push(50, 0, ACQ, 0, 0, 5, 0);
    push(51, 0, TMO, 0, 1, 5, 0);
    push(55, 0, TMO, 0, 1, 5, 0);
    for (int i = 0; i < 56; i++) begin
      trim = (i % 2 == 1) ? P13 : TGL;
      tick(1);
    end

    // 4b: div change leaves TIMEOUT
    div = 5'd20; trim = P15;
    push(1, 0, ACQ, 0, 0, 5, 0);
    push(6, 0, LCK, 1, 0, 5, 0);
    tick(7);

    // enable low: IDLE, lock_time held
    enable = 1'b0;
    push(1, 0, IDLE, 0, 0, 5, 0);
    tick(2);

    // 5: TOL=1, popcount 13/14 locks
    en1 = 1'b1; div1 = 5'd17;
    push(1, 1, ACQ, 0, 0, 0, 0);
    push(6, 1, LCK, 1, 0, 5, 0);
    push(8, 1, LCK, 1, 0, 5, 0);
    for (int i = 0; i < 9; i++) begin
      trim1 = (i % 2 == 1) ? P14 : P13;
      tick(1);
    end

    // 5b: popcount 13/15 never settles
    div1 = 5'd18;
    push(1, 1, ACQ, 0, 0, 5, 0);
    push(50, 1, ACQ, 0, 0, 5, 0);
    push(51, 1, TMO, 0, 1, 5, 0);
    for (int i = 0; i < 53; i++) begin
      trim1 = (i % 2 == 1) ? P13 : P15;
      tick(1);
    end

    // 6: reset in ACQUIRE cycle 3 clears everything
    enable = 1'b1;
    push(1, 0, ACQ, 0, 0, 5, 0);
    push(3, 0, ACQ, 0, 0, 5, 0);
    tick(3);
    resetb = 1'b0;
    push(1, 0, IDLE, 0, 0, 0, 0);
    push(1, 1, IDLE, 0, 0, 0, 0);
    tick(1);
    resetb = 1'b1;
    push(1, 0, ACQ, 0, 0, 0, 0);
    push(6, 0, LCK, 1, 0, 5, 0);
    tick(8);

    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(posedge osc);
    end
    if (sb.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
